router_register: RTL and testbench

Data-path register stage of the 1x3 packet router, instantiated as `router_reg` between the input port and the destination FIFOs. It latches the header byte, forwards header/payload/parity bytes to `dout` under FSM control, parks one byte when the FIFO is full, and computes running XOR parity. At packet end it compares the running parity against the received parity byte and flags `error`.

---
 rtl/router_register.sv | 122 ++++++++++++
 tb/tb_router_register.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_register.sv
// Data-path register stage of the 1x3 router: header latch, byte forwarding,
// single-byte park while the FIFO is full, running XOR parity and check.
module router_register (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic       fifo_full,
    input  logic       rst_int_reg,
    input  logic       detect_add,
    input  logic       ld_state,
    input  logic       laf_state,
    input  logic       full_state,
    input  logic       lfd_state,
    input  logic [7:0] data_in,
    output logic       parity_done,
    output logic       low_pkt_valid,
    output logic       error,
    output logic [7:0] dout
);

    localparam int unsigned DATA_W = 8;
    localparam logic [1:0]  ADDR_INVALID = 2'b11;

    logic [DATA_W-1:0] r_hdr_byte;
    logic [DATA_W-1:0] r_full_byte;
    logic [DATA_W-1:0] r_int_parity;
    logic [DATA_W-1:0] r_pkt_parity;
    logic [DATA_W-1:0] r_dout;
    logic              r_parity_done;
    logic              r_low_pkt_valid;
    logic              r_error;

    logic w_hdr_load;
    logic w_parity_set;

    // Header is captured only for a valid destination address.
    assign w_hdr_load   = detect_add && pkt_valid && (data_in[1:0] != ADDR_INVALID);

    // Parity byte arrives either directly in load or from the parked slot after full.
    assign w_parity_set = !r_parity_done &&
                          ((ld_state && !fifo_full && !pkt_valid) ||
                           (laf_state && r_low_pkt_valid));

    // Header byte latch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hdr_byte <= '0;
        end else if (w_hdr_load) begin
            r_hdr_byte <= data_in;
        end
    end

    // Output byte select; a byte arriving while the FIFO is full is parked.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dout      <= '0;
            r_full_byte <= '0;
        end else if (lfd_state) begin
            r_dout <= r_hdr_byte;
        end else if (ld_state && !fifo_full) begin
            r_dout <= data_in;
        end else if (ld_state && fifo_full) begin
            r_full_byte <= data_in;
        end else if (laf_state) begin
            r_dout <= r_full_byte;
        end
    end

    // Running parity over header and payload; the parity byte itself is excluded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_int_parity <= '0;
        end else if (detect_add) begin
            r_int_parity <= '0;
        end else if (lfd_state) begin
            r_int_parity <= r_int_parity ^ r_hdr_byte;
        end else if (ld_state && pkt_valid && !full_state) begin
            r_int_parity <= r_int_parity ^ data_in;
        end
    end

    // Received parity capture, latched once per packet.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_parity_done <= 1'b0;
            r_pkt_parity  <= '0;
        end else if (detect_add) begin
            r_parity_done <= 1'b0;
        end else if (w_parity_set) begin
            r_parity_done <= 1'b1;
            r_pkt_parity  <= data_in;
        end
    end

    // End-of-payload flag; the FSM clear wins over a concurrent set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_low_pkt_valid <= 1'b0;
        end else if (rst_int_reg) begin
            r_low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            r_low_pkt_valid <= 1'b1;
        end
    end

    // Parity compare, refreshed each cycle once the received parity is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_error <= 1'b0;
        end else if (detect_add) begin
            r_error <= 1'b0;
        end else if (r_parity_done) begin
            r_error <= (r_int_parity != r_pkt_parity);
        end
    end

    assign dout          = r_dout;
    assign parity_done   = r_parity_done;
    assign low_pkt_valid = r_low_pkt_valid;
    assign error         = r_error;

endmodule

// File: tb/tb_router_register.sv
// Directed bench for router_register with a dout scoreboard queue.
module tb_router_register;

    logic       clk;
    logic       rst;
    logic       pkt_valid;
    logic       fifo_full;
    logic       rst_int_reg;
    logic       detect_add;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       error;
    logic [7:0] dout;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [7:0] exp_q[$];
    logic [7:0] payload[8];
    logic [7:0] par;

    router_register dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_valid     (pkt_valid),
        .fifo_full     (fifo_full),
        .rst_int_reg   (rst_int_reg),
        .detect_add    (detect_add),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .lfd_state     (lfd_state),
        .data_in       (data_in),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .error         (error),
        .dout          (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        assert (act === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one edge, then retire any pending dout expectation.
    task automatic tick();
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) chk("dout_sb", dout, exp_q.pop_front());
    endtask

    task automatic ctrl_idle();
        pkt_valid   = 1'b0;
        fifo_full   = 1'b0;
        rst_int_reg = 1'b0;
        detect_add  = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        lfd_state   = 1'b0;
    endtask

    // Header in decode-address, then header forwarded in load-first-data.
    task automatic send_header(input logic [7:0] hdr, input logic [7:0] exp_hdr);
        ctrl_idle();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = hdr;
        tick();
        ctrl_idle();
        pkt_valid  = 1'b1;
        lfd_state  = 1'b1;
        exp_q.push_back(exp_hdr);
        tick();
    endtask

    initial begin
        ctrl_idle();
        data_in = 8'h00;
        rst = 1'b0;
        tick();
        chk("rst_dout", dout, 8'h00);
        chk("rst_parity_done", 8'(parity_done), 8'h00);
        chk("rst_low_pkt_valid", 8'(low_pkt_valid), 8'h00);
        chk("rst_error", 8'(error), 8'h00);
        rst = 1'b1;

        // Good packet: len 8, addr 0.
        send_header(8'h20, 8'h20);
        par = 8'h20;
        for (int i = 0; i < 8; i++) begin
            payload[i] = 8'($urandom);
            par = par ^ payload[i];
        end
        for (int i = 0; i < 8; i++) begin
            ctrl_idle();
            ld_state  = 1'b1;
            pkt_valid = 1'b1;
            data_in   = payload[i];
            exp_q.push_back(payload[i]);
            tick();
        end
        ctrl_idle();
        ld_state = 1'b1;
        data_in  = par;
        exp_q.push_back(par);
        tick();
        chk("good_parity_done", 8'(parity_done), 8'h01);
        chk("good_low_pkt_valid", 8'(low_pkt_valid), 8'h01);
        chk("good_error_before", 8'(error), 8'h00);
        ctrl_idle();
        tick();
        chk("good_error", 8'(error), 8'h00);

        // Clear of low_pkt_valid wins over a concurrent set.
        ctrl_idle();
        ld_state    = 1'b1;
        rst_int_reg = 1'b1;
        data_in     = 8'h3C;
        exp_q.push_back(8'h3C);
        tick();
        chk("rst_int_clear", 8'(low_pkt_valid), 8'h00);
        chk("rst_int_pd_hold", 8'(parity_done), 8'h01);
        rst_int_reg = 1'b0;
        tick();
        chk("low_pkt_reset", 8'(low_pkt_valid), 8'h01);
        ctrl_idle();
        tick();

        // Bad packet: len 5, addr 2, parity corrupted by +5.
        send_header(8'h16, 8'h16);
        chk("bad_pd_cleared", 8'(parity_done), 8'h00);
        par = 8'h16;
        for (int i = 0; i < 5; i++) begin
            payload[i] = 8'($urandom);
            par = par ^ payload[i];
            ctrl_idle();
            ld_state  = 1'b1;
            pkt_valid = 1'b1;
            data_in   = payload[i];
            exp_q.push_back(payload[i]);
            tick();
        end
        ctrl_idle();
        ld_state = 1'b1;
        data_in  = par + 8'd5;
        exp_q.push_back(par + 8'd5);
        tick();
        chk("bad_parity_done", 8'(parity_done), 8'h01);
        ctrl_idle();
        tick();
        chk("bad_error", 8'(error), 8'h01);
        tick();
        chk("bad_error_stable", 8'(error), 8'h01);

        // Address 3 header must not overwrite the stored header; clears flags.
        send_header(8'h23, 8'h16);
        chk("inval_error_clr", 8'(error), 8'h00);
        chk("inval_pd_clr", 8'(parity_done), 8'h00);

        // FIFO full: byte parked, dout held, then released in load-after-full.
        ctrl_idle();
        ld_state  = 1'b1;
        pkt_valid = 1'b1;
        fifo_full = 1'b1;
        data_in   = 8'hA5;
        exp_q.push_back(8'h16);
        tick();
        ctrl_idle();
        full_state = 1'b1;
        fifo_full  = 1'b1;
        data_in    = 8'h5A;
        exp_q.push_back(8'h16);
        tick();
        ctrl_idle();
        laf_state = 1'b1;
        pkt_valid = 1'b1;
        data_in   = 8'h77;
        exp_q.push_back(8'hA5);
        tick();
        chk("laf_pd_from_low", 8'(parity_done), 8'h01);

        // Reset mid-packet aborts everything.
        ctrl_idle();
        ld_state  = 1'b1;
        pkt_valid = 1'b0;
        data_in   = 8'hEE;
        rst       = 1'b0;
        tick();
        chk("mid_rst_dout", dout, 8'h00);
        chk("mid_rst_pd", 8'(parity_done), 8'h00);
        chk("mid_rst_low", 8'(low_pkt_valid), 8'h00);
        chk("mid_rst_err", 8'(error), 8'h00);
        rst = 1'b1;
        ctrl_idle();
        tick();

        // After reset the stored header is 0.
        send_header(8'h23, 8'h00);

        if (exp_q.size() != 0) begin
            n_total++;
            n_fail++;
            $error("FAIL sb_drain: observed %0d expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
